// File: rtl/aes_pkg.sv
// Shared AES definitions used by the block-to-byte serializer and the
// downstream byte-collect stages.
//   AES_BLOCK_BITS / AES_BYTE_BITS / AES_NUM_BYTES : block geometry
//   aes_byte()       : byte i of a 128-bit vector, byte 0 = bits [127:120]
//   ark_state_t      : FSM states of add_round_key_serializer
package aes_pkg;

  localparam int unsigned AES_BLOCK_BITS = 128;
  localparam int unsigned AES_BYTE_BITS  = 8;
  localparam int unsigned AES_NUM_BYTES  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ark_state_t;

  // Byte 0 is the most significant byte; shifting left by 8*idx brings the
  // requested byte to the top so no variable part-select is needed.
  function automatic logic [AES_BYTE_BITS-1:0] aes_byte(
    input logic [AES_BLOCK_BITS-1:0] block,
    input logic [3:0]                idx
  );
    logic [AES_BLOCK_BITS-1:0] shifted;
    shifted = block << {idx, 3'b000};
    return shifted[AES_BLOCK_BITS-1 -: AES_BYTE_BITS];
  endfunction

endpackage

// File: rtl/add_round_key_serializer.sv
// AddRoundKey followed by a block-to-byte serializer. One 128-bit state and
// round key are accepted per handshake, their XOR is registered, and the 16
// result bytes are streamed (byte 0 first) to the s-box input.
//   clock, reset                : rising-edge clock, async active-high reset
//   input_valid / input_ready   : block handshake
//   input_state, input_key      : 128-bit operands, byte i = [127-8i -: 8]
//   output_valid / output_ready : byte handshake
//   output_data                 : current byte of state ^ key
//   output_last                 : high with byte 15
//   output_index                : index of the current byte
// All outputs come straight from registers or a mux of registers.
module add_round_key_serializer
  import aes_pkg::*;
#(
  parameter int unsigned NUM_BYTES  = AES_NUM_BYTES,
  parameter int unsigned BYTE_WIDTH = AES_BYTE_BITS
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            input_valid,
  output logic                            input_ready,
  input  logic [NUM_BYTES*BYTE_WIDTH-1:0] input_state,
  input  logic [NUM_BYTES*BYTE_WIDTH-1:0] input_key,
  output logic                            output_valid,
  input  logic                            output_ready,
  output logic [BYTE_WIDTH-1:0]           output_data,
  output logic                            output_last,
  output logic [$clog2(NUM_BYTES)-1:0]    output_index
);

  localparam int unsigned BLOCK_BITS = NUM_BYTES * BYTE_WIDTH;
  localparam int unsigned CW         = $clog2(NUM_BYTES);
  localparam logic [CW-1:0] LAST_INDEX = CW'(NUM_BYTES - 1);

  ark_state_t            state;
  logic [BLOCK_BITS-1:0] buffer;
  logic [CW-1:0]         count;
  logic                  input_ready_q;
  logic                  output_valid_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      buffer         <= '0;
      count          <= '0;
      input_ready_q  <= 1'b0;
      output_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (input_valid && input_ready_q) begin
            buffer         <= input_state ^ input_key;
            count          <= '0;
            state          <= SEND;
            input_ready_q  <= 1'b0;
            output_valid_q <= 1'b1;
          end else begin
            // Covers the first edge after reset release.
            input_ready_q <= 1'b1;
          end
        end
        SEND: begin
          if (output_valid_q && output_ready) begin
            if (count == LAST_INDEX) begin
              state          <= IDLE;
              output_valid_q <= 1'b0;
              input_ready_q  <= 1'b1;
              count          <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign input_ready  = input_ready_q;
  assign output_valid = output_valid_q;
  assign output_data  = aes_byte(buffer, count);
  assign output_index = count;
  assign output_last  = (count == LAST_INDEX);

endmodule

// File: tb/tb_add_round_key_serializer.sv
// Self-checking bench for add_round_key_serializer: a queue-based model of
// the byte stream runs alongside the DUT and is compared every cycle, a
// table of known blocks checks the collected bytes, and directed sequences
// cover reset, backpressure, overlapping requests and mid-block reset.
module tb_add_round_key_serializer;

  logic         clock = 1'b0;
  logic         reset;
  logic         input_valid;
  logic         input_ready;
  logic [127:0] input_state;
  logic [127:0] input_key;
  logic         output_valid;
  logic         output_ready;
  logic [7:0]   output_data;
  logic         output_last;
  logic [3:0]   output_index;

  add_round_key_serializer #(.NUM_BYTES(16), .BYTE_WIDTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_state  (input_state),
    .input_key    (input_key),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data),
    .output_last  (output_last),
    .output_index (output_index)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [127:0] state;
    logic [127:0] key;
    logic [127:0] result;
  } vec_t;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: bytes still owed downstream, plus the ready flag.
  logic [7:0] mq[$];
  bit         m_ready;

  logic [7:0] obs[$];   // bytes actually transferred by the DUT
  int         acc[$];   // edge numbers at which a block was accepted
  int         edge_count = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [127:0] x;
    if (reset) begin
      mq.delete();
      m_ready = 1'b0;
    end else if (mq.size() != 0) begin
      if (output_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_ready = 1'b1;
      end
    end else if (!m_ready) begin
      m_ready = 1'b1;
    end else if (input_valid) begin
      x = input_state ^ input_key;
      for (int i = 0; i < 16; i++) mq.push_back(x[127-8*i -: 8]);
      m_ready = 1'b0;
    end
  endtask

  task automatic check_model();
    check("input_ready", 128'(input_ready), 128'(m_ready));
    check("output_valid", 128'(output_valid), 128'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("output_data", 128'(output_data), 128'(mq[0]));
      check("output_index", 128'(output_index), 128'(16 - mq.size()));
      check("output_last", 128'(output_last), 128'(mq.size() == 1));
    end
  endtask

  task automatic tick();
    if (!reset && input_valid && input_ready) acc.push_back(edge_count);
    if (!reset && output_valid && output_ready) obs.push_back(output_data);
    @(posedge clock);
    edge_count++;
    model_edge();
    #1;
    check_model();
  endtask

  task automatic send_block(input logic [127:0] s, input logic [127:0] k);
    int n;
    input_state = s;
    input_key   = k;
    input_valid = 1'b1;
    n = 0;
    while (!input_ready && n < 40) begin
      tick();
      n++;
    end
    if (!input_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: input_ready got 0 expected 1");
    end
    tick();
    input_valid = 1'b0;
  endtask

  task automatic check_obs(input string name, input logic [127:0] exp);
    logic [127:0] e;
    e = exp;
    check({name, "_count"}, 128'(obs.size()), 128'(16));
    for (int i = 0; i < 16 && i < obs.size(); i++)
      check(name, 128'(obs[i]), 128'(e[127-8*i -: 8]));
  endtask

  localparam logic [127:0] FIPS_STATE = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_XOR   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{FIPS_STATE, FIPS_KEY, FIPS_XOR};
    tbl[1] = '{128'h00112233445566778899aabbccddeeff, 128'h0,
               128'h00112233445566778899aabbccddeeff};
    tbl[2] = '{FIPS_STATE, FIPS_STATE, 128'h0};
    tbl[3] = '{128'h0, {128{1'b1}}, {128{1'b1}}};
    tbl[4] = '{{128{1'b1}}, 128'h0123456789abcdef0123456789abcdef,
               128'hfedcba9876543210fedcba9876543210};

    reset = 1'b1; input_valid = 1'b0; input_state = '0; input_key = '0;
    output_ready = 1'b1;
    mq.delete(); m_ready = 1'b0;

    // Reset held: outputs at reset values throughout.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_data", 128'(output_data), 128'(0));
      check("reset_index", 128'(output_index), 128'(0));
      check("reset_last", 128'(output_last), 128'(0));
    end
    reset = 1'b0;
    check_model();          // still not ready before the first edge
    tick();                 // ready after exactly one edge

    // Known blocks with output_ready tied high.
    foreach (tbl[t]) begin
      obs.delete();
      send_block(tbl[t].state, tbl[t].key);
      for (int i = 0; i < 17; i++) tick();
      check_obs($sformatf("table%0d_byte", t), tbl[t].result);
    end

    // Backpressure after byte 1.
    obs.delete();
    send_block(FIPS_STATE, FIPS_KEY);
    tick(); tick();
    output_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_data", 128'(output_data), 128'(8'he3));
      check("bp_index", 128'(output_index), 128'(2));
    end
    output_ready = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check_obs("bp_byte", FIPS_XOR);

    // Second request held during SEND: accepted 17 edges after the first.
    acc.delete();
    send_block(FIPS_STATE, FIPS_KEY);
    input_state = '0;
    input_key   = '1;
    input_valid = 1'b1;
    for (int i = 0; i < 40 && acc.size() < 2; i++) tick();
    input_valid = 1'b0;
    check("overlap_accepts", 128'(acc.size()), 128'(2));
    if (acc.size() >= 2)
      check("overlap_spacing", 128'(acc[1] - acc[0]), 128'(17));
    obs.delete();
    for (int i = 0; i < 17; i++) tick();
    check_obs("overlap_byte", {128{1'b1}});

    // Asynchronous reset after byte 5 has been transferred.
    send_block(FIPS_STATE, FIPS_KEY);
    for (int i = 0; i < 6; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    mq.delete(); m_ready = 1'b0;
    check_model();
    check("async_rst_data", 128'(output_data), 128'(0));
    check("async_rst_index", 128'(output_index), 128'(0));
    tick(); tick();
    reset = 1'b0;
    tick();
    obs.delete();
    send_block(tbl[1].state, tbl[1].key);
    for (int i = 0; i < 17; i++) tick();
    check_obs("post_rst_byte", tbl[1].result);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (!input_valid || input_ready) begin
        input_valid = ($urandom_range(0, 2) != 0);
        input_state = {$urandom, $urandom, $urandom, $urandom};
        input_key   = {$urandom, $urandom, $urandom, $urandom};
      end
      output_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
